// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with press/release debounce
// Drives one row low at a time, debounces the first key found, and reports its hex code.
module keypad_scanner #(
    parameter int SCAN_CYCLES     = 12000,
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old,
    output logic       key_valid
);

    // Counters only ever hold 0 .. N-1, so clog2(N) bits suffice.
    localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    state_t        state, state_d;
    logic [3:0]    sync1, colsync;
    logic [1:0]    row, row_d;
    logic [1:0]    col, col_d;
    logic [SW-1:0] dwell, dwell_d;
    logic [DW-1:0] db_cnt, db_d;
    logic [3:0]    rows_d, new_d, old_d;
    logic          valid_d;
    logic [1:0]    low_col;
    logic          col_level;

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Two-flop synchronizer; idle (all released) value is all ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= 4'b1111;
            colsync <= 4'b1111;
        end else begin
            sync1   <= cols;
            colsync <= sync1;
        end
    end

    // Lowest-index low column wins when several keys share the row.
    always_comb begin
        low_col = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!colsync[i]) low_col = 2'(i);
        end
    end

    assign col_level = colsync[col];

    always_comb begin
        state_d = state;
        row_d   = row;
        col_d   = col;
        dwell_d = dwell;
        db_d    = db_cnt;
        new_d   = digit_new;
        old_d   = digit_old;
        valid_d = 1'b0;
        case (state)
            SCAN: begin
                if (dwell == SCAN_LAST) begin
                    dwell_d = '0;
                    if (colsync != 4'b1111) begin
                        state_d = PRESS_DB;
                        col_d   = low_col;
                        db_d    = '0;
                    end else begin
                        row_d = row + 2'd1;
                    end
                end else begin
                    dwell_d = dwell + SW'(1);
                end
            end
            PRESS_DB: begin
                if (col_level) begin
                    state_d = SCAN;
                    dwell_d = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_d = HELD;
                    old_d   = digit_new;
                    new_d   = key_code(row, col);
                    valid_d = 1'b1;
                end else begin
                    db_d = db_cnt + DW'(1);
                end
            end
            HELD: begin
                if (col_level) begin
                    state_d = RELEASE_DB;
                    db_d    = '0;
                end
            end
            RELEASE_DB: begin
                if (!col_level) begin
                    state_d = HELD;
                end else if (db_cnt == DB_LAST) begin
                    state_d = SCAN;
                    row_d   = 2'd0;
                    dwell_d = '0;
                end else begin
                    db_d = db_cnt + DW'(1);
                end
            end
            default: begin
                state_d = SCAN;
                row_d   = 2'd0;
                dwell_d = '0;
                db_d    = '0;
            end
        endcase
        rows_d = ~(4'b0001 << row_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SCAN;
            row       <= 2'd0;
            col       <= 2'd0;
            dwell     <= '0;
            db_cnt    <= '0;
            rows      <= 4'b1110;
            digit_new <= 4'h0;
            digit_old <= 4'h0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_d;
            row       <= row_d;
            col       <= col_d;
            dwell     <= dwell_d;
            db_cnt    <= db_d;
            rows      <= rows_d;
            digit_new <= new_d;
            digit_old <= old_d;
            key_valid <= valid_d;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - randomized bench for keypad_scanner against a behavioural model
// A physical keypad model closes the row/column loop; a sequential reference thread predicts outputs.
module tb_keypad_scanner;

    localparam int SCAN = 4;
    localparam int DEB  = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cols;
    logic [3:0] rows;
    logic [3:0] digit_new, digit_old;
    logic       key_valid;

    logic [15:0] keys = 16'h0;
    logic [3:0]  code_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                   4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

    int checks = 0;
    int failures = 0;
    int pulses = 0;
    int exp_pulses = 0;

    logic [3:0] exp_rows = 4'b1110, exp_new = 4'h0, exp_old = 4'h0;
    logic       exp_valid = 1'b0;
    logic [3:0] m_s1 = 4'hF, m_s2 = 4'hF, cols_s = 4'hF;
    int         m_phase = 0;

    keypad_scanner #(.SCAN_CYCLES(SCAN), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk       (clk),
        .reset     (reset),
        .cols      (cols),
        .rows      (rows),
        .digit_new (digit_new),
        .digit_old (digit_old),
        .key_valid (key_valid)
    );

    always #5 clk = ~clk;

    // Pressed key (r,c) shorts row r to column c; columns pulled high otherwise.
    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!rows[r] && keys[r*4+c]) cols[c] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int key_idx(input logic [3:0] hex);
        for (int i = 0; i < 16; i++) if (code_tab[i] == hex) return i;
        return 0;
    endfunction

    // ---------------- reference model ----------------
    always @(negedge clk) cols_s = cols;

    task automatic cyc(output logic [3:0] cs, output bit ab);
        @(posedge clk);
        ab        = reset;
        cs        = m_s2;
        exp_valid = 1'b0;
        m_s2      = m_s1;
        m_s1      = cols_s;
    endtask

    task automatic model_run();
        int r, c, n;
        logic [3:0] cs;
        bit ab, accepted, released;
        r = 0;
        exp_rows = 4'b1110;
        forever begin
            for (int k = 0; k < SCAN; k++) begin
                cyc(cs, ab);
                if (ab) return;
            end
            if (cs == 4'hF) begin
                r = (r + 1) % 4;
                exp_rows = 4'hF;
                exp_rows[r] = 1'b0;
                continue;
            end
            c = 0;
            while (cs[c]) c++;
            m_phase = 1;
            n = 0;
            accepted = 0;
            while (1) begin
                cyc(cs, ab);
                if (ab) return;
                if (cs[c]) break;
                n++;
                if (n == DEB) begin
                    accepted = 1;
                    break;
                end
            end
            m_phase = 0;
            if (!accepted) continue;
            exp_old   = exp_new;
            exp_new   = code_tab[r*4+c];
            exp_valid = 1'b1;
            // n < 0: key held; n >= 0: consecutive released cycles seen
            released = 0;
            n = -1;
            while (!released) begin
                cyc(cs, ab);
                if (ab) return;
                if (n < 0) begin
                    if (cs[c]) n = 0;
                end else if (!cs[c]) begin
                    n = -1;
                end else begin
                    n++;
                    if (n == DEB) released = 1;
                end
            end
            r = 0;
            exp_rows = 4'b1110;
        end
    endtask

    initial begin
        forever begin
            exp_rows  = 4'b1110;
            exp_new   = 4'h0;
            exp_old   = 4'h0;
            exp_valid = 1'b0;
            m_s1      = 4'hF;
            m_s2      = 4'hF;
            m_phase   = 0;
            wait (reset == 1'b0);
            model_run();
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (reset) begin
            check("rst_rows", 32'(rows), 32'(4'b1110));
            check("rst_digit_new", 32'(digit_new), 32'h0);
            check("rst_digit_old", 32'(digit_old), 32'h0);
            check("rst_key_valid", 32'(key_valid), 32'h0);
        end else begin
            check("rows", 32'(rows), 32'(exp_rows));
            check("digit_new", 32'(digit_new), 32'(exp_new));
            check("digit_old", 32'(digit_old), 32'(exp_old));
            check("key_valid", 32'(key_valid), 32'(exp_valid));
        end
        if (key_valid) pulses++;
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic tap(input logic [3:0] hex, input int hold, input int gap);
        keys[key_idx(hex)] = 1'b1;
        step(hold);
        keys[key_idx(hex)] = 1'b0;
        step(gap);
    endtask

    initial begin
        int k1, k2;
        step(3);
        reset = 1'b0;

        step(40);
        check("idle_pulses", 32'(pulses), 32'd0);
        check("idle_digit_new", 32'(digit_new), 32'h0);

        // key 5, clean press then release
        keys[key_idx(4'h5)] = 1'b1;
        step(60);
        exp_pulses = 1;
        check("k5_pulses", 32'(pulses), 32'(exp_pulses));
        check("k5_digit_new", 32'(digit_new), 32'h5);
        check("k5_digit_old", 32'(digit_old), 32'h0);
        check("k5_model_new", 32'(exp_new), 32'h5);
        check("k5_rows_held", 32'(rows), 32'(4'b1101));
        keys = 16'h0;
        step(40);

        // 9 then A
        tap(4'h9, 60, 40);
        tap(4'hA, 60, 40);
        exp_pulses += 2;
        check("9A_pulses", 32'(pulses), 32'(exp_pulses));
        check("9A_digit_new", 32'(digit_new), 32'hA);
        check("9A_digit_old", 32'(digit_old), 32'h9);

        // key 0 bouncing every 3 cycles, then steady
        for (int i = 0; i < 10; i++) begin
            keys[key_idx(4'h0)] = ~keys[key_idx(4'h0)];
            step(3);
        end
        check("bounce_no_pulse", 32'(pulses), 32'(exp_pulses));
        keys[key_idx(4'h0)] = 1'b1;
        step(60);
        exp_pulses += 1;
        check("bounce_pulses", 32'(pulses), 32'(exp_pulses));
        check("bounce_digit_new", 32'(digit_new), 32'h0);
        check("bounce_digit_old", 32'(digit_old), 32'hA);
        keys = 16'h0;
        step(40);

        // 3 held, 7 added, 3 released
        keys[key_idx(4'h3)] = 1'b1;
        step(60);
        exp_pulses += 1;
        keys[key_idx(4'h7)] = 1'b1;
        step(40);
        check("rollover_pulses", 32'(pulses), 32'(exp_pulses));
        keys[key_idx(4'h3)] = 1'b0;
        step(80);
        exp_pulses += 1;
        check("rollover7_pulses", 32'(pulses), 32'(exp_pulses));
        check("rollover7_new", 32'(digit_new), 32'h7);
        check("rollover7_old", 32'(digit_old), 32'h3);
        keys = 16'h0;
        step(40);

        // reset while F is debouncing
        keys[key_idx(4'hF)] = 1'b1;
        for (int i = 0; i < 100 && m_phase != 1; i++) step(1);
        check("f_press_db_reached", 32'(m_phase), 32'd1);
        step(3);
        reset = 1'b1;
        #1;
        check("f_rst_rows", 32'(rows), 32'(4'b1110));
        check("f_rst_digit_new", 32'(digit_new), 32'h0);
        check("f_rst_digit_old", 32'(digit_old), 32'h0);
        check("f_rst_key_valid", 32'(key_valid), 32'h0);
        step(2);
        keys = 16'h0;
        step(2);
        reset = 1'b0;
        step(60);
        check("f_no_pulse", 32'(pulses), 32'(exp_pulses));
        check("f_digit_new", 32'(digit_new), 32'h0);

        // randomized presses, bounces, multi-key and resets
        for (int it = 0; it < 40; it++) begin
            k1 = int'($urandom_range(0, 15));
            keys = 16'h0;
            keys[k1] = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                k2 = int'($urandom_range(0, 15));
                keys[k2] = 1'b1;
            end
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(2, 8)) begin
                    keys[k1] = ~keys[k1];
                    step(int'($urandom_range(1, 5)));
                end
                keys[k1] = 1'b1;
            end
            step(int'($urandom_range(0, 60)));
            if ($urandom_range(0, 9) == 0) begin
                reset = 1'b1;
                step(int'($urandom_range(1, 3)));
                reset = 1'b0;
            end
            keys = 16'h0;
            step(int'($urandom_range(0, 40)));
        end
        step(60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_CYCLES, default 12000: clk cycles each row is driven during scanning (0.5 ms at 24 MHz).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 240000: consecutive stable cycles required to accept a press or a release (10 ms at 24 MHz).
REQ-003 SHALL have port clk, input, 1: single clock, fed by the internal HSOSC at 24 MHz; all state on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port cols, input, 4: keypad column lines, active-low, externally pulled up, asynchronous to clk.
REQ-006 SHALL have port rows, output, 4: keypad row drives, active-low, one-hot-zero, registered.
REQ-007 SHALL have port digit_new, output, 4: hex code of the most recently accepted key; feeds the display multiplexer's right digit.
REQ-008 SHALL have port digit_old, output, 4: hex code of the key accepted before digit_new; feeds the left digit.
REQ-009 SHALL have port key_valid, output, 1: one-cycle pulse on each accepted press.

Function
REQ-010 SHALL pass cols through a 2-flop synchronizer; all decisions use the synchronized value (colsync); 2-cycle input latency.
REQ-011 SHALL implement states SCAN, PRESS_DB, HELD, RELEASE_DB.
REQ-012 SCAN SHALL drive row r low (others high), hold r for SCAN_CYCLES cycles, then advance r, wrapping 3 -> 0.
REQ-013 SCAN SHALL sample colsync only on the last cycle of each row dwell; if any bit is 0, latch r and the lowest-index low column c, and enter PRESS_DB with the debounce counter cleared.
REQ-014 Row drive SHALL stay fixed on the latched row in PRESS_DB, HELD and RELEASE_DB.
REQ-015 PRESS_DB SHALL return to SCAN (same row, dwell counter cleared) if colsync[c] reads 1 on any cycle before the count completes.
REQ-016 PRESS_DB SHALL enter HELD once colsync[c] has read 0 for DEBOUNCE_CYCLES consecutive cycles.
REQ-017 On that same edge: digit_old <= digit_new, digit_new <= code(r,c), key_valid = 1 for exactly one cycle.
REQ-018 code(r,c) SHALL be: row0 = 1,2,3,A; row1 = 4,5,6,B; row2 = 7,8,9,C; row3 = E,0,F,D (cols 0..3).
REQ-019 HELD SHALL enter RELEASE_DB when colsync[c] reads 1; other columns and rows are ignored (no roll-over, no repeat).
REQ-020 RELEASE_DB SHALL return to HELD if colsync[c] reads 0 before the count completes, with no new key_valid.
REQ-021 RELEASE_DB SHALL enter SCAN at row 0 after colsync[c] has read 1 for DEBOUNCE_CYCLES consecutive cycles.
REQ-022 Counters SHALL be wide enough for their parameter and SHALL never wrap; no key_valid outside REQ-017.
REQ-023 Simultaneous keys in different columns on the same row SHALL resolve to the lowest column index.

Reset
REQ-024 Reset asserted SHALL immediately force: state SCAN, r = 0, rows = 4'b1110, digit_new = 0, digit_old = 0, key_valid = 0, all counters 0, synchronizer flops = 4'b1111.
REQ-025 Reset asserted mid-debounce or while HELD SHALL discard the pending key; after release, scanning resumes at row 0 with no pulse.

Verification (SCAN_CYCLES=4, DEBOUNCE_CYCLES=8)
REQ-026 Reset, no keys -> rows cycles 1110,1101,1011,0111,1110 every 4 cycles; digits 0; key_valid never high.
REQ-027 Press key "5" (row1/col1) clean, then release -> one key_valid pulse; digit_new=5, digit_old=0; rows holds 1101 until 8 released cycles, then resumes at 1110.
REQ-028 Press "9" then "A" sequentially -> digit_new=A, digit_old=9, exactly two pulses.
REQ-029 Key "0" bounces low/high every 3 cycles for 30 cycles then steady low -> exactly one pulse, digit_new=0, only after 8 steady cycles.
REQ-030 While "3" is held, press "7" too -> no second pulse; after "3" released, the still-held "7" is accepted on the next scan.
REQ-031 Assert reset during PRESS_DB of "F" -> all outputs return to reset values at once; no pulse for F.
